// File: rtl/alien_march_ctrl.sv
// Alien formation march scheduler.
// Decides when the formation steps sideways, drops a row and reverses, and
// when a wave ends in a clear (pause, level up) or an invasion (game over).
// Step, Drop and Level_Clear are Mealy pulses issued in the decision cycle;
// the position registers downstream act on them at the same clock edge.
module alien_march_ctrl #(
    parameter logic [19:0] MIN_PERIOD    = 20'd50000,
    parameter logic [19:0] PER_ALIEN_CYC = 20'd4000,
    parameter logic [19:0] LEVEL_CYC     = 20'd20000,
    parameter logic [2:0]  MAX_LEVEL     = 3'd7,
    parameter logic [23:0] CLEAR_PAUSE   = 24'd5000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [49:0] Aliens_Grid,
    input  logic        Left_Edge,
    input  logic        Right_Edge,
    input  logic        Reached_Bottom,
    output logic        Step,
    output logic        Drop,
    output logic        Move_Right,
    output logic        Level_Clear,
    output logic [2:0]  Level,
    output logic        Game_Over,
    output logic [5:0]  Alive_Count
);

    typedef enum logic [1:0] {IDLE, MARCH, PAUSE, OVER} state_t;

    state_t      state, state_next;
    logic [23:0] counter, counter_next;
    logic [2:0]  level_next;
    logic        move_right_next;
    logic [5:0]  pop;
    logic [21:0] base, lvl_sub;
    logic [20:0] period;
    logic        tick;
    logic        edge_hit;

    // Popcount of the live-alien bitmap
    always_comb begin
        pop = '0;
        for (int i = 0; i < 50; i++) pop = pop + {5'd0, Aliens_Grid[i]};
    end

    // Registered alive count; every decision uses this delayed copy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) Alive_Count <= '0;
        else       Alive_Count <= pop;
    end

    // Move period from population and level, floored at MIN_PERIOD
    always_comb begin
        base    = {2'b0, MIN_PERIOD} + 22'(Alive_Count) * {2'b0, PER_ALIEN_CYC};
        lvl_sub = 22'(Level) * {2'b0, LEVEL_CYC};
        if (base >= lvl_sub + {2'b0, MIN_PERIOD}) period = 21'(base - lvl_sub);
        else                                      period = {1'b0, MIN_PERIOD};
    end

    // >= rather than == so a period that shrinks mid-interval fires at once
    assign tick     = (counter >= ({3'b0, period} - 24'd1));
    assign edge_hit = Move_Right ? Right_Edge : Left_Edge;

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            counter    <= '0;
            Level      <= '0;
            Move_Right <= 1'b1;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            Level      <= level_next;
            Move_Right <= move_right_next;
        end
    end

    // Next-state logic: bottom beats clear beats tick
    always_comb begin
        state_next      = state;
        counter_next    = counter;
        level_next      = Level;
        move_right_next = Move_Right;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next   = MARCH;
                    counter_next = '0;
                end
            end
            MARCH: begin
                if (Reached_Bottom) begin
                    state_next   = OVER;
                    counter_next = '0;
                end else if (Alive_Count == 6'd0) begin
                    state_next      = PAUSE;
                    counter_next    = '0;
                    level_next      = (Level >= MAX_LEVEL) ? Level : Level + 3'd1;
                    move_right_next = 1'b1;
                end else if (tick) begin
                    counter_next = '0;
                    if (edge_hit) move_right_next = ~Move_Right;
                end else begin
                    counter_next = counter + 24'd1;
                end
            end
            PAUSE: begin
                // Bottom contact is ignored here while the formation is repositioned
                if (counter >= CLEAR_PAUSE - 24'd1) begin
                    state_next   = MARCH;
                    counter_next = '0;
                end else begin
                    counter_next = counter + 24'd1;
                end
            end
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // Output pulses, mutually exclusive by construction of the priority chain
    always_comb begin
        Step        = 1'b0;
        Drop        = 1'b0;
        Level_Clear = 1'b0;
        Game_Over   = (state == OVER);
        if (state == MARCH && !Reached_Bottom) begin
            if (Alive_Count == 6'd0) begin
                Level_Clear = 1'b1;
            end else if (tick) begin
                Drop = edge_hit;
                Step = ~edge_hit;
            end
        end
    end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Directed bench for alien_march_ctrl with small timing parameters
// (MIN_PERIOD=4, PER_ALIEN_CYC=2, LEVEL_CYC=10, CLEAR_PAUSE=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alien_march_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [49:0] Aliens_Grid = '0;
    logic        Left_Edge = 1'b0;
    logic        Right_Edge = 1'b0;
    logic        Reached_Bottom = 1'b0;
    logic        Step, Drop, Move_Right, Level_Clear, Game_Over;
    logic [2:0]  Level;
    logic [5:0]  Alive_Count;

    int tests = 0;
    int fails = 0;

    logic [49:0] all_grid;
    logic [49:0] one_grid;

    alien_march_ctrl #(
        .MIN_PERIOD(20'd4), .PER_ALIEN_CYC(20'd2), .LEVEL_CYC(20'd10),
        .MAX_LEVEL(3'd7), .CLEAR_PAUSE(24'd8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Aliens_Grid(Aliens_Grid),
        .Left_Edge(Left_Edge), .Right_Edge(Right_Edge), .Reached_Bottom(Reached_Bottom),
        .Step(Step), .Drop(Drop), .Move_Right(Move_Right), .Level_Clear(Level_Clear),
        .Level(Level), .Game_Over(Game_Over), .Alive_Count(Alive_Count)
    );

    always #5 Clk = ~Clk;

    // Advance falling edges until a pulse appears; n = edges advanced, -1 on timeout
    task automatic wait_ev(input int max, output int n, output logic [2:0] seen);
        n = -1;
        seen = 3'b000;
        for (int i = 1; i <= max; i++) begin
            @(negedge Clk);
            if (Step || Drop || Level_Clear) begin
                n = i;
                seen = {Level_Clear, Drop, Step};
                break;
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Leaves us at the first MARCH falling edge (counter = 0)
    task automatic start_game();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Aliens_Grid = all_grid;
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        tests++;
        if ({Step, Drop, Level_Clear, Game_Over} !== 4'b0000) begin
            $display("FAIL reset_pulses: got %b expected 0000", {Step, Drop, Level_Clear, Game_Over});
            fails++;
        end
        tests++;
        if (Move_Right !== 1'b1) begin
            $display("FAIL reset_move_right: got %b expected 1", Move_Right);
            fails++;
        end
        tests++;
        if (Level !== 3'd0) begin
            $display("FAIL reset_level: got %0d expected 0", Level);
            fails++;
        end
        tests++;
        if (Alive_Count !== 6'd0) begin
            $display("FAIL reset_alive: got %0d expected 0", Alive_Count);
            fails++;
        end
    endtask

    task automatic test_full_grid();
        int n;
        logic [2:0] seen;
        Aliens_Grid = all_grid;
        Left_Edge = 1'b0;
        Right_Edge = 1'b0;
        do_reset();
        start_game();
        tests++;
        if (Alive_Count !== 6'd50) begin
            $display("FAIL full_alive: got %0d expected 50", Alive_Count);
            fails++;
        end
        // p = 4 + 50*2 = 104; counter starts at 0 here, fires at 103
        wait_ev(200, n, seen);
        tests++;
        if (n !== 103 || seen !== 3'b001) begin
            $display("FAIL full_first_step: got n=%0d ev=%b expected n=103 ev=001", n, seen);
            fails++;
        end
        wait_ev(200, n, seen);
        tests++;
        if (n !== 104 || seen !== 3'b001) begin
            $display("FAIL full_second_step: got n=%0d ev=%b expected n=104 ev=001", n, seen);
            fails++;
        end
        tests++;
        if (Move_Right !== 1'b1) begin
            $display("FAIL full_move_right: got %b expected 1", Move_Right);
            fails++;
        end
    endtask

    task automatic test_edge_drop();
        int n;
        logic [2:0] seen;
        Aliens_Grid = one_grid;
        Right_Edge = 1'b1;
        Left_Edge = 1'b0;
        do_reset();
        start_game();
        // p = 4 + 2 = 6
        wait_ev(20, n, seen);
        tests++;
        if (n !== 5 || seen !== 3'b010) begin
            $display("FAIL edge_drop: got n=%0d ev=%b expected n=5 ev=010", n, seen);
            fails++;
        end
        @(negedge Clk);
        tests++;
        if (Move_Right !== 1'b0) begin
            $display("FAIL edge_reverse: got %b expected 0", Move_Right);
            fails++;
        end
        // Moving left, right edge still high but irrelevant
        wait_ev(20, n, seen);
        tests++;
        if (n !== 5 || seen !== 3'b001) begin
            $display("FAIL edge_step_left: got n=%0d ev=%b expected n=5 ev=001", n, seen);
            fails++;
        end
        @(negedge Clk);
        Left_Edge = 1'b1;
        wait_ev(20, n, seen);
        tests++;
        if (n !== 5 || seen !== 3'b010) begin
            $display("FAIL edge_both_drop: got n=%0d ev=%b expected n=5 ev=010", n, seen);
            fails++;
        end
        @(negedge Clk);
        tests++;
        if (Move_Right !== 1'b1) begin
            $display("FAIL edge_reverse_back: got %b expected 1", Move_Right);
            fails++;
        end
        Left_Edge = 1'b0;
        Right_Edge = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        logic [2:0] seen;
        Aliens_Grid = one_grid;
        do_reset();
        start_game();
        @(negedge Clk);
        @(negedge Clk);
        Aliens_Grid = '0;
        wait_ev(20, n, seen);
        tests++;
        if (n !== 1 || seen !== 3'b100) begin
            $display("FAIL clear_pulse: got n=%0d ev=%b expected n=1 ev=100", n, seen);
            fails++;
        end
        @(negedge Clk);
        tests++;
        if (Level !== 3'd1 || Level_Clear !== 1'b0) begin
            $display("FAIL clear_level: got lvl=%0d lc=%b expected lvl=1 lc=0", Level, Level_Clear);
            fails++;
        end
        // Bottom contact during the pause must not end the game
        Aliens_Grid = one_grid;
        Reached_Bottom = 1'b1;
        repeat (7) @(negedge Clk);
        tests++;
        if (Game_Over !== 1'b0) begin
            $display("FAIL pause_ignores_bottom: got %b expected 0", Game_Over);
            fails++;
        end
        Reached_Bottom = 1'b0;
        // Pause ends after 8 cycles; level 1 with one alien clamps p to 4
        wait_ev(20, n, seen);
        tests++;
        if (n !== 4 || seen !== 3'b001) begin
            $display("FAIL clamp_step: got n=%0d ev=%b expected n=4 ev=001", n, seen);
            fails++;
        end
        Aliens_Grid = '0;
        wait_ev(20, n, seen);
        tests++;
        if (n !== 1 || seen !== 3'b100) begin
            $display("FAIL clear_again: got n=%0d ev=%b expected n=1 ev=100", n, seen);
            fails++;
        end
        // Empty grid: each clear follows a full pause plus one MARCH cycle
        for (int k = 0; k < 5; k++) begin
            wait_ev(20, n, seen);
            tests++;
            if (n !== 9 || seen !== 3'b100) begin
                $display("FAIL clear_loop%0d: got n=%0d ev=%b expected n=9 ev=100", k, n, seen);
                fails++;
            end
        end
        wait_ev(20, n, seen);
        tests++;
        if (Level !== 3'd7 || seen !== 3'b100) begin
            $display("FAIL clear_at_max: got lvl=%0d ev=%b expected lvl=7 ev=100", Level, seen);
            fails++;
        end
        @(negedge Clk);
        tests++;
        if (Level !== 3'd7) begin
            $display("FAIL level_saturate: got %0d expected 7", Level);
            fails++;
        end
    endtask

    task automatic test_shrink();
        int n;
        logic [2:0] seen;
        Aliens_Grid = all_grid;
        do_reset();
        start_game();
        repeat (50) @(negedge Clk);
        Aliens_Grid = one_grid;
        wait_ev(20, n, seen);
        tests++;
        if (n !== 1 || seen !== 3'b001) begin
            $display("FAIL shrink_step: got n=%0d ev=%b expected n=1 ev=001", n, seen);
            fails++;
        end
        wait_ev(20, n, seen);
        tests++;
        if (n !== 6 || seen !== 3'b001) begin
            $display("FAIL shrink_next: got n=%0d ev=%b expected n=6 ev=001", n, seen);
            fails++;
        end
    endtask

    task automatic test_over();
        int n;
        logic [2:0] seen;
        Aliens_Grid = one_grid;
        do_reset();
        start_game();
        @(negedge Clk);
        Aliens_Grid = '0;
        @(negedge Clk);
        Reached_Bottom = 1'b1;
        #1;
        tests++;
        if ({Level_Clear, Drop, Step} !== 3'b000) begin
            $display("FAIL over_priority: got %b expected 000", {Level_Clear, Drop, Step});
            fails++;
        end
        @(negedge Clk);
        tests++;
        if (Game_Over !== 1'b1 || Level !== 3'd0) begin
            $display("FAIL over_state: got go=%b lvl=%0d expected go=1 lvl=0", Game_Over, Level);
            fails++;
        end
        Reached_Bottom = 1'b0;
        Aliens_Grid = one_grid;
        start_game();
        wait_ev(20, n, seen);
        tests++;
        if (n !== -1 || Game_Over !== 1'b1) begin
            $display("FAIL over_sticky: got n=%0d go=%b expected n=-1 go=1", n, Game_Over);
            fails++;
        end
    endtask

    task automatic test_reset_mid_step();
        int n;
        logic [2:0] seen;
        Aliens_Grid = one_grid;
        do_reset();
        start_game();
        wait_ev(20, n, seen);
        tests++;
        if (n !== 5 || seen !== 3'b001) begin
            $display("FAIL mid_pre_step: got n=%0d ev=%b expected n=5 ev=001", n, seen);
            fails++;
        end
        Reset = 1'b1;
        #1;
        tests++;
        if ({Step, Drop, Level_Clear, Game_Over} !== 4'b0000 || Move_Right !== 1'b1) begin
            $display("FAIL mid_reset_out: got %b mr=%b expected 0000 mr=1",
                     {Step, Drop, Level_Clear, Game_Over}, Move_Right);
            fails++;
        end
        tests++;
        if (Level !== 3'd0 || Alive_Count !== 6'd0) begin
            $display("FAIL mid_reset_regs: got lvl=%0d ac=%0d expected 0 0", Level, Alive_Count);
            fails++;
        end
        @(negedge Clk);
        Reset = 1'b0;
        wait_ev(10, n, seen);
        tests++;
        if (n !== -1) begin
            $display("FAIL mid_idle: got n=%0d expected -1", n);
            fails++;
        end
        start_game();
        wait_ev(20, n, seen);
        tests++;
        if (n !== 5 || seen !== 3'b001) begin
            $display("FAIL mid_restart: got n=%0d ev=%b expected n=5 ev=001", n, seen);
            fails++;
        end
    endtask

    initial begin
        all_grid = '1;
        one_grid = 50'd1 << 17;
        test_reset();
        test_full_grid();
        test_edge_drop();
        test_clear();
        test_shrink();
        test_over();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
